// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Time-shares one external combinational ALU between two requesters.
//   At most one operation issues per cycle. The issue slot is open when the
//   response register is empty or is being drained this cycle; ties are
//   resolved round-robin. The ALU result is captured into a one-entry
//   response register, one cycle after the grant.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid[1:0]        per-requester request
//   req_ready[1:0]        per-requester grant (combinational, one-hot or zero)
//   req_r1, req_r2        packed operands {req1, req0}, DWL bits each
//   req_shamt[9:0]        packed 5-bit shift amounts {req1, req0}
//   req_sel[5:0]          packed 3-bit ALU selects {req1, req0}
//   alu_r1, alu_r2        operands to the shared ALU
//   alu_shamt, alu_sel    shift amount and select to the shared ALU
//   alu_ado, alu_zero     combinational ALU result and zero flag
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                index of the requester owning the response
//   rsp_data, rsp_zero    registered ALU result and zero flag
module alu_arbiter #(
  parameter int DWL = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*DWL-1:0] req_r1,
  input  logic [2*DWL-1:0] req_r2,
  input  logic [9:0]       req_shamt,
  input  logic [5:0]       req_sel,
  output logic [DWL-1:0]   alu_r1,
  output logic [DWL-1:0]   alu_r2,
  output logic [4:0]       alu_shamt,
  output logic [2:0]       alu_sel,
  input  logic [DWL-1:0]   alu_ado,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [DWL-1:0]   rsp_data,
  output logic             rsp_zero
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state;
  logic   last_grant;
  logic   slot_open;
  logic   grant_any;
  logic   grant_idx;

  assign slot_open = (state == EMPTY) || rsp_ready;

  // Issue stage: arbitration and ALU operand steering (same cycle)
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (!rst && slot_open) begin
      unique case (req_valid)
        2'b01: begin grant_any = 1'b1; grant_idx = 1'b0; end
        2'b10: begin grant_any = 1'b1; grant_idx = 1'b1; end
        // Tie: the requester not granted most recently wins.
        2'b11: begin grant_any = 1'b1; grant_idx = ~last_grant; end
        default: begin grant_any = 1'b0; grant_idx = 1'b0; end
      endcase
    end
  end

  always_comb begin
    req_ready = 2'b00;
    alu_r1    = '0;
    alu_r2    = '0;
    alu_shamt = '0;
    alu_sel   = 3'b000;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
      if (grant_idx) begin
        alu_r1    = req_r1[2*DWL-1:DWL];
        alu_r2    = req_r2[2*DWL-1:DWL];
        alu_shamt = req_shamt[9:5];
        alu_sel   = req_sel[5:3];
      end else begin
        alu_r1    = req_r1[DWL-1:0];
        alu_r2    = req_r2[DWL-1:0];
        alu_shamt = req_shamt[4:0];
        alu_sel   = req_sel[2:0];
      end
    end
  end

  // Response stage: capture ALU result, hold while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (grant_any) begin
        last_grant <= grant_idx;
        rsp_data   <= alu_ado;
        rsp_zero   <= alu_zero;
        rsp_id     <= grant_idx;
      end
      unique case (state)
        EMPTY: begin
          if (grant_any) begin
            state     <= FULL;
            rsp_valid <= 1'b1;
          end
        end
        FULL: begin
          if (rsp_ready && !grant_any) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DWL, default 32, sets the data word length of all operand and result ports.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  2  per-requester operation request; bit i = requester i.
REQ-005 req_ready  output  2  per-requester grant; bit i high = requester i's operation accepted this cycle.
REQ-006 req_r1  input  2*DWL  packed operand R1, {req1, req0}.
REQ-007 req_r2  input  2*DWL  packed operand R2, {req1, req0}.
REQ-008 req_shamt  input  10  packed 5-bit shift amounts, {req1, req0}.
REQ-009 req_sel  input  6  packed 3-bit ALU select codes, {req1, req0}.
REQ-010 alu_r1, alu_r2  output  DWL each  operands driven to the shared ALU.
REQ-011 alu_shamt  output  5  shift amount driven to the shared ALU.
REQ-012 alu_sel  output  3  select code driven to the shared ALU.
REQ-013 alu_ado  input  DWL  combinational ALU result.
REQ-014 alu_zero  input  1  combinational ALU zero flag.
REQ-015 rsp_valid  output  1  response register holds a result.
REQ-016 rsp_ready  input  1  consumer accepts response this cycle.
REQ-017 rsp_id  output  1  requester index that owns the response.
REQ-018 rsp_data  output  DWL  registered ALU result.
REQ-019 rsp_zero  output  1  registered ALU zero flag.

Function
REQ-020 Block SHALL time-share one combinational ALU between two requesters, one operation issued per cycle at most.
REQ-021 Issue slot open when !rsp_valid || rsp_ready; no grant SHALL occur while slot closed.
REQ-022 When slot open and exactly one req_valid bit set, that requester SHALL be granted.
REQ-023 When slot open and both set, the requester not granted most recently SHALL be granted (round-robin via 1-bit last_grant register).
REQ-024 last_grant SHALL update only on a grant; it holds otherwise.
REQ-025 req_ready SHALL be combinational, one-hot or zero, never asserted for a requester with req_valid low.
REQ-026 During a grant, alu_r1/alu_r2/alu_shamt/alu_sel SHALL carry the granted requester's fields in the same cycle.
REQ-027 With no grant, ALU inputs SHALL be driven to all-zero (sel 3'b000).
REQ-028 On a grant, rsp_data<=alu_ado, rsp_zero<=alu_zero, rsp_id<=granted index, rsp_valid<=1 at the next posedge: latency 1 cycle.
REQ-029 FSM states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-030 EMPTY: grant -> FULL; no grant -> EMPTY.
REQ-031 FULL & rsp_ready & grant -> FULL with new result (back-to-back, throughput 1/cycle).
REQ-032 FULL & rsp_ready & no grant -> EMPTY.
REQ-033 FULL & !rsp_ready -> FULL; rsp_data/rsp_zero/rsp_id SHALL remain stable, req_ready=2'b00.
REQ-034 Requester deasserting req_valid before grant SHALL lose no state; no request is latched before grant.
REQ-035 ALU results are passed through unmodified; no width extension or truncation.

Reset
REQ-036 While rst high at posedge: state EMPTY, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, last_grant=1 (requester 0 wins first tie).
REQ-037 req_ready SHALL be 2'b00 during any cycle rst is high.
REQ-038 Reset mid-operation SHALL discard any pending response; no response emitted for a request granted in the reset cycle.

Verification
REQ-039 req_valid=01, req0 r1=5 r2=3 sel=010, rsp_ready=1 -> req_ready=01 same cycle; next cycle rsp_valid=1, rsp_data=8, rsp_zero=0, rsp_id=0.
REQ-040 After reset, req_valid=11 held 4 cycles, rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1 one cycle later.
REQ-041 req1 r1=7 r2=7 sel=110 granted, rsp_ready=0 for 3 cycles with req_valid=01 -> rsp_data=0, rsp_zero=1, rsp_id=1 stable; req_ready=00 until rsp_ready=1, then req0 granted same cycle.
REQ-042 req0 sel=111 r2=1 shamt=4 -> rsp_data=16; req0 sel=100 r2=0x80000000 r1=4 -> rsp_data=0xF8000000.
REQ-043 rst asserted in a cycle with rsp_valid=1 and req_valid=11 -> next cycle rsp_valid=0, req_ready=00 during rst; first tie after release grants requester 0.
